// File: rtl/ext_obi_resp_mem.sv
// OBI responder word memory with programmable grant wait states and a fixed-latency response pipe.
// Optional out-of-range checking is enabled by defining EXT_OBI_RESP_MEM_OOB_CHECK_EN.
module ext_obi_resp_mem #(
   parameter int unsigned NUM_WORDS = 1024,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned GNT_WAIT  = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        oob_o
);

   localparam int unsigned AW        = $clog2(NUM_WORDS);
   localparam bit          ZERO_WAIT = (GNT_WAIT == 0);
   localparam logic [2:0]  WAIT_LOAD = (GNT_WAIT > 0) ? 3'(GNT_WAIT - 1) : 3'd0;
   localparam logic [31:0] OOB_RDATA = 32'hBADC_AB1E;

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("ext_obi_resp_mem: LATENCY must be within 1..4");
   end
   if (GNT_WAIT > 7) begin : g_bad_gnt_wait
      $error("ext_obi_resp_mem: GNT_WAIT must be within 0..7");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [2:0]      cnt_r;
   logic [2:0]      cnt_nxt_s;
   logic            gnt_s;
   logic            accept_s;
   logic            oob_hit_s;
   logic [AW-1:0]   idx_s;
   logic [31:0]     rd_data_s;
   logic            unused_s;
   logic [31:0]     mem_r [NUM_WORDS];
   logic            pipe_vld_r [LATENCY];
   logic [31:0]     pipe_dat_r [LATENCY];

   assign idx_s    = addr_i[AW+1:2];
   assign accept_s = req_i & gnt_s;
   assign gnt_o    = gnt_s;

   // Grant FSM state and wait counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Grant FSM next state; a dropped request in WAIT abandons the wait.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (req_i && !ZERO_WAIT) begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = WAIT_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!req_i || cnt_r == 3'd0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - 3'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 3'd0;
         end
      endcase
   end

   // Grant FSM output.
   always_comb begin
      gnt_s = 1'b0;
      case (state_r)
         ST_IDLE: gnt_s = req_i & ZERO_WAIT;
         ST_WAIT: gnt_s = req_i & (cnt_r == 3'd0);
         default: gnt_s = 1'b0;
      endcase
   end

`ifdef EXT_OBI_RESP_MEM_OOB_CHECK_EN
   logic oob_r;

   assign oob_hit_s = |addr_i[31:AW+2];
   assign oob_o     = oob_r;
   assign unused_s  = ^addr_i[1:0];

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oob_r <= 1'b0;
      end else if (accept_s && oob_hit_s) begin
         oob_r <= 1'b1;
      end
   end
`else
   assign oob_hit_s = 1'b0;
   assign oob_o     = 1'b0;
   assign unused_s  = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

   // Byte-lane writes at the grant; memory contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (accept_s && we_i && !oob_hit_s && be_i[b]) begin
            mem_r[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Read data captured in the grant cycle; writes respond with zero.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      if (we_i) begin
         rd_data_s = 32'h0000_0000;
      end else if (oob_hit_s) begin
         rd_data_s = OOB_RDATA;
      end else begin
         rd_data_s = mem_r[idx_s];
      end
   end

   // Non-stalling response shift; data stages hold their last valid value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_vld_r[i] <= 1'b0;
            pipe_dat_r[i] <= 32'h0000_0000;
         end
      end else begin
         pipe_vld_r[0] <= accept_s;
         if (accept_s) begin
            pipe_dat_r[0] <= rd_data_s;
         end
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_r[i] <= pipe_vld_r[i-1];
            if (pipe_vld_r[i-1]) begin
               pipe_dat_r[i] <= pipe_dat_r[i-1];
            end
         end
      end
   end

   assign rvalid_o = pipe_vld_r[LATENCY-1];
   assign rdata_o  = pipe_dat_r[LATENCY-1];

endmodule

// File: tb/tb_ext_obi_resp_mem.sv
// Directed bench for ext_obi_resp_mem: three instances cover zero-wait, GNT_WAIT=3 and LATENCY=3.
// Expectations for the wrap/out-of-range case follow EXT_OBI_RESP_MEM_OOB_CHECK_EN.
module tb_ext_obi_resp_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req   [3];
   logic        we    [3];
   logic [3:0]  be    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic        gnt   [3];
   logic        rvalid[3];
   logic [31:0] rdata [3];
   logic        oob   [3];

   int errors = 0;
   int checks = 0;

`ifdef EXT_OBI_RESP_MEM_OOB_CHECK_EN
   localparam logic [31:0] EXP_WRAP_RD  = 32'hBADC_AB1E;
   localparam logic        EXP_OOB      = 1'b1;
   localparam logic [31:0] EXP_AFTER_WR = 32'hDEAD_BEEF;
`else
   localparam logic [31:0] EXP_WRAP_RD  = 32'hDEAD_BEEF;
   localparam logic        EXP_OOB      = 1'b0;
   localparam logic [31:0] EXP_AFTER_WR = 32'h1234_5678;
`endif

   always #5 clk = ~clk;

   ext_obi_resp_mem #(.NUM_WORDS(1024), .LATENCY(1), .GNT_WAIT(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
      .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .oob_o(oob[0]));

   ext_obi_resp_mem #(.NUM_WORDS(1024), .LATENCY(1), .GNT_WAIT(3)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
      .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .oob_o(oob[1]));

   ext_obi_resp_mem #(.NUM_WORDS(1024), .LATENCY(3), .GNT_WAIT(0)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
      .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .oob_o(oob[2]));

   task automatic set_in(input int k, input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
      req[k]   = r;
      we[k]    = w;
      be[k]    = b;
      addr[k]  = a;
      wdata[k] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || oob[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst%0d: gnt=%b rvalid=%b rdata=%h oob=%b, required 0 0 00000000 0",
                     k, gnt[k], rvalid[k], rdata[k], oob[k]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      @(negedge clk);
      set_in(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      #1;
      checks++;
      if (gnt[0] !== 1'b1) begin
         errors++; $display("FAIL basic_wr_gnt: got %b, required 1", gnt[0]);
      end
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
         errors++; $display("FAIL basic_wr_rsp: rvalid=%b rdata=%h, required 1 00000000", rvalid[0], rdata[0]);
      end
      set_in(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      #1;
      checks++;
      if (gnt[0] !== 1'b1) begin
         errors++; $display("FAIL basic_rd_gnt: got %b, required 1", gnt[0]);
      end
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL basic_rd_rsp: rvalid=%b rdata=%h, required 1 deadbeef", rvalid[0], rdata[0]);
      end
      set_in(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b0) begin
         errors++; $display("FAIL basic_pulse: rvalid=%b, required 0", rvalid[0]);
      end
   endtask

   task automatic test_byte_enables();
      @(negedge clk);
      set_in(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
      @(negedge clk);
      set_in(0, 1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
      @(negedge clk);
      set_in(0, 1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
         errors++; $display("FAIL be_zero_rsp: rvalid=%b rdata=%h, required 1 00000000", rvalid[0], rdata[0]);
      end
      set_in(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h11BB_33DD) begin
         errors++; $display("FAIL be_merge: rvalid=%b rdata=%h, required 1 11bb33dd", rvalid[0], rdata[0]);
      end
      set_in(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic test_addr_wrap();
      @(negedge clk);
      set_in(0, 1'b1, 1'b0, 4'hF, 32'h1010, 32'h0);
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== EXP_WRAP_RD || oob[0] !== EXP_OOB) begin
         errors++;
         $display("FAIL wrap_read: rvalid=%b rdata=%h oob=%b, required 1 %h %b",
                  rvalid[0], rdata[0], oob[0], EXP_WRAP_RD, EXP_OOB);
      end
      set_in(0, 1'b1, 1'b1, 4'hF, 32'h1010, 32'h1234_5678);
      @(negedge clk);
      set_in(0, 1'b1, 1'b0, 4'hF, 32'h13, 32'h0);
      @(negedge clk);
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== EXP_AFTER_WR || oob[0] !== EXP_OOB) begin
         errors++;
         $display("FAIL wrap_write: rvalid=%b rdata=%h oob=%b, required 1 %h %b",
                  rvalid[0], rdata[0], oob[0], EXP_AFTER_WR, EXP_OOB);
      end
      set_in(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic test_grant_wait();
      int cyc;
      for (int pass = 0; pass < 3; pass++) begin
         @(negedge clk);
         if (pass == 2) begin
            set_in(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
            @(negedge clk);
            set_in(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               checks++;
               if (gnt[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
                  errors++; $display("FAIL wait_abort: gnt=%b rvalid=%b, required 0 0", gnt[1], rvalid[1]);
               end
            end
         end
         set_in(1, 1'b1, (pass == 0), 4'hF, 32'h10, 32'hCAFE_F00D);
         #1;
         checks++;
         if (gnt[1] !== 1'b0) begin
            errors++; $display("FAIL wait_early_gnt: got %b, required 0", gnt[1]);
         end
         cyc = 0;
         while (gnt[1] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         checks++;
         if (cyc != 3) begin
            errors++; $display("FAIL wait_gnt_cycles pass%0d: got %0d, required 3", pass, cyc);
         end
         @(negedge clk);
         checks++;
         if (rvalid[1] !== 1'b1 || rdata[1] !== ((pass == 0) ? 32'h0 : 32'hCAFE_F00D)) begin
            errors++; $display("FAIL wait_rsp pass%0d: rvalid=%b rdata=%h", pass, rvalid[1], rdata[1]);
         end
         set_in(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic        exp_v;
      logic [31:0] exp_d;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         exp_v = (k >= 3 && k <= 10);
         exp_d = (k <= 6) ? 32'h0 : 32'(k - 6);
         checks++;
         if (rvalid[2] !== exp_v || (exp_v && rdata[2] !== exp_d)) begin
            errors++;
            $display("FAIL b2b_rsp cycle%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid[2], rdata[2], exp_v, exp_d);
         end
         if (k < 4) set_in(2, 1'b1, 1'b1, 4'hF, 32'(4 * k), 32'(k + 1));
         else if (k < 8) set_in(2, 1'b1, 1'b0, 4'hF, 32'(4 * (k - 4)), 32'h0);
         else set_in(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         #1;
         if (k < 8) begin
            checks++;
            if (gnt[2] !== 1'b1) begin
               errors++; $display("FAIL b2b_gnt cycle%0d: got %b, required 1", k, gnt[2]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_in(2, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      @(negedge clk);
      set_in(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rvalid[2] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop cycle%0d: rvalid=%b, required 0", i, rvalid[2]);
         end
      end
      checks++;
      if (oob[0] !== 1'b0) begin
         errors++; $display("FAIL rst_oob_clear: got %b, required 0", oob[0]);
      end
      set_in(2, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      #1;
      checks++;
      if (gnt[2] !== 1'b1) begin
         errors++; $display("FAIL rst_mid_gnt: got %b, required 1", gnt[2]);
      end
      @(negedge clk);
      set_in(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      checks++;
      if (rvalid[2] !== 1'b1 || rdata[2] !== 32'h2) begin
         errors++; $display("FAIL rst_mid_rsp: rvalid=%b rdata=%h, required 1 00000002", rvalid[2], rdata[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_enables();
      test_addr_wrap();
      test_grant_wait();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
